// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: Control_Unit <-> mult/div sequencer handshake and datapath controls.
// Optional abort/aborted signals exist only when MULDIV_ABORT_EN is defined.
interface muldiv_sequencer_if #(
    parameter int CNT_W = 6
);
    logic             start;
    logic [1:0]       op;
    logic             divisor_zero;
    logic             busy;
    logic             done;
    logic             div_zero_exc;
    logic             illegal_op;
    logic             mult_init;
    logic             div_init;
    logic             div_src_sel;
    logic             hl_sel;
    logic             hl_load;
    logic [CNT_W-1:0] cycle_count;
`ifdef MULDIV_ABORT_EN
    logic             abort;
    logic             aborted;
    modport master (output start, op, divisor_zero, abort,
                    input  busy, done, div_zero_exc, illegal_op, mult_init, div_init,
                           div_src_sel, hl_sel, hl_load, cycle_count, aborted);
    modport slave  (input  start, op, divisor_zero, abort,
                    output busy, done, div_zero_exc, illegal_op, mult_init, div_init,
                           div_src_sel, hl_sel, hl_load, cycle_count, aborted);
`else
    modport master (output start, op, divisor_zero,
                    input  busy, done, div_zero_exc, illegal_op, mult_init, div_init,
                           div_src_sel, hl_sel, hl_load, cycle_count);
    modport slave  (input  start, op, divisor_zero,
                    output busy, done, div_zero_exc, illegal_op, mult_init, div_init,
                           div_src_sel, hl_sel, hl_load, cycle_count);
`endif
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: drives init pulses, source/result selects and HI/LO load for the shared mult/div units.
// Define MULDIV_ABORT_EN to add abort/aborted (cancel from INIT or RUN).
module muldiv_sequencer #(
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input logic                clk,
    input logic                reset,
    muldiv_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, INIT, RUN, WRITE, EXC} state_t;

    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] last;
    logic             active;

    assign last   = (op_q == 2'b00) ? MULT_LAST : DIV_LAST;
    assign active = (state_q == INIT) || (state_q == RUN) || (state_q == WRITE);

`ifdef MULDIV_ABORT_EN
    logic aborted_q, aborted_d;
    always_ff @(posedge clk or negedge reset)
        if (!reset) aborted_q <= 1'b0;
        else        aborted_q <= aborted_d;
    assign bus.aborted = aborted_q;
`endif

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state_q <= IDLE;
            op_q    <= 2'b00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end

    // op is also latched on the exception path so EXC knows which pulse to raise
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
`ifdef MULDIV_ABORT_EN
        aborted_d = 1'b0;
`endif
        case (state_q)
            IDLE:
                if (bus.start) begin
                    op_d    = bus.op;
                    cnt_d   = '0;
                    state_d = (bus.op == 2'b11 || (bus.op != 2'b00 && bus.divisor_zero)) ? EXC : INIT;
                end
            INIT: state_d = RUN;
            RUN: begin
                cnt_d   = (cnt_q == last) ? '0 : cnt_q + 1'b1;
                state_d = (cnt_q == last) ? WRITE : RUN;
            end
            default: state_d = IDLE;
        endcase
`ifdef MULDIV_ABORT_EN
        if (bus.abort && (state_q == INIT || state_q == RUN)) begin
            state_d   = IDLE;
            cnt_d     = '0;
            aborted_d = 1'b1;
        end
`endif
    end

    assign bus.busy         = state_q != IDLE;
    assign bus.done         = state_q == WRITE;
    assign bus.hl_load      = state_q == WRITE;
    assign bus.div_zero_exc = (state_q == EXC) && (op_q != 2'b11);
    assign bus.illegal_op   = (state_q == EXC) && (op_q == 2'b11);
    assign bus.mult_init    = (state_q == INIT) && (op_q == 2'b00);
    assign bus.div_init     = (state_q == INIT) && (op_q != 2'b00);
    assign bus.hl_sel       = active && (op_q == 2'b00);
    assign bus.div_src_sel  = active && (op_q == 2'b10);
    assign bus.cycle_count  = cnt_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: cycle-offset reference model plus directed and random stimulus.
module tb_muldiv_sequencer;
    localparam int M = 32;
    localparam int D = 32;
    localparam int W = 6;
    localparam int AB = 0, HL = 1, HS = 2, SRC = 3, DI = 4, MI = 5, ILL = 6, DZ = 7, DN = 8, BS = 9;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    muldiv_sequencer_if #(.CNT_W(W)) bus();
    muldiv_sequencer #(.MULT_CYCLES(M), .DIV_CYCLES(D), .CNT_W(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int cyc = 0;
    always @(posedge clk) cyc++;

    // model: mk = cycles since acceptance (0 = idle), mexc = pending one-cycle pulse kind
    int         mk = 0;
    int         mexc = 0;
    logic [1:0] mop = 2'b00;
    logic       ab;
    logic       act_ab;
`ifdef MULDIV_ABORT_EN
    assign ab     = bus.abort;
    assign act_ab = bus.aborted;
`else
    assign ab     = 1'b0;
    assign act_ab = 1'b0;
`endif

    function automatic int nlen(logic [1:0] o);
        return (o == 2'b00) ? M : D;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mk = 0;
            mexc = 0;
        end else if (mexc != 0) begin
            mexc = 0;
        end else if (mk == 0) begin
            if (bus.start) begin
                if (bus.op == 2'b11) mexc = 1;
                else if (bus.op != 2'b00 && bus.divisor_zero) mexc = 2;
                else begin
                    mk = 1;
                    mop = bus.op;
                end
            end
        end else if (ab && mk <= nlen(mop) + 1) begin
            mk = 0;
            mexc = 3;
        end else if (mk == nlen(mop) + 2) mk = 0;
        else mk++;
    end

    logic [15:0] act, expv;
    assign act = {bus.busy, bus.done, bus.div_zero_exc, bus.illegal_op, bus.mult_init, bus.div_init,
                  bus.div_src_sel, bus.hl_sel, bus.hl_load, act_ab, bus.cycle_count};
    always_comb begin
        int n;
        n = nlen(mop);
        expv = {mk != 0 || mexc != 0, mk == n + 2, mexc == 2, mexc == 1, mk == 1 && mop == 2'b00,
                mk == 1 && mop != 2'b00, mk != 0 && mop == 2'b10, mk != 0 && mop == 2'b00, mk == n + 2,
                mexc == 3, (mk >= 2 && mk <= n + 1) ? W'(mk - 2) : W'(0)};
    end

    int cmp_c = 0, err_c = 0, cmp_d = 0, err_d = 0;
    int ev[10];
    int last_ev[10];
    int base[10];
    initial for (int i = 0; i < 10; i++) begin ev[i] = 0; last_ev[i] = 0; end

    always @(negedge clk) begin
        cmp_c++;
        if (act !== expv) begin
            err_c++;
            $display("FAIL cycle %0d outputs got %h want %h", cyc, act, expv);
        end
        for (int i = 0; i < 10; i++)
            if (act[W+i]) begin ev[i]++; last_ev[i] = cyc; end
    end

    task automatic check(input string name, input int got, input int want);
        cmp_d++;
        if (got != want) begin
            err_d++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    int s_cyc;
    task automatic snap();
        for (int i = 0; i < 10; i++) base[i] = ev[i];
    endtask
    function automatic int dl(int i);
        return ev[i] - base[i];
    endfunction
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic go(input logic [1:0] o, input logic z);
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.divisor_zero = z;
        s_cyc = cyc;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0; bus.op = 2'b00; bus.divisor_zero = 1'b0;
`ifdef MULDIV_ABORT_EN
        bus.abort = 1'b0;
`endif
        idle(3);
        check("reset_outputs", int'(act), 0);
        reset = 1'b1;
        idle(2);

        snap(); go(2'b00, 1'b0); idle(40);
        check("mult_init_count", dl(MI), 1);
        check("mult_init_offset", last_ev[MI] - s_cyc, 1);
        check("mult_div_init", dl(DI), 0);
        check("mult_busy_cycles", dl(BS), 34);
        check("mult_hl_sel_cycles", dl(HS), 34);
        check("mult_done_count", dl(DN), 1);
        check("mult_done_latency", last_ev[DN] - s_cyc, 34);
        check("mult_hl_with_done", last_ev[HL], last_ev[DN]);

        snap(); go(2'b10, 1'b0); idle(40);
        check("div_init_count", dl(DI), 1);
        check("div_init_offset", last_ev[DI] - s_cyc, 1);
        check("div_src_cycles", dl(SRC), 34);
        check("div_hl_sel_cycles", dl(HS), 0);
        check("div_done_latency", last_ev[DN] - s_cyc, 34);

        snap(); go(2'b01, 1'b1); idle(4);
        check("dz_exc_count", dl(DZ), 1);
        check("dz_exc_offset", last_ev[DZ] - s_cyc, 1);
        check("dz_div_init", dl(DI), 0);
        check("dz_hl_load", dl(HL), 0);
        check("dz_done", dl(DN), 0);
        check("dz_busy_cycles", dl(BS), 1);

        snap(); go(2'b11, 1'($urandom_range(0, 1))); idle(4);
        check("ill_count", dl(ILL), 1);
        check("ill_init", dl(MI) + dl(DI), 0);
        check("ill_busy_cycles", dl(BS), 1);

        snap(); go(2'b00, 1'b0); idle(8);
        @(negedge clk); bus.start = 1'b1; bus.op = 2'($urandom);
        @(negedge clk); bus.start = 1'b0;
        idle(9);
        bus.start = 1'b1; bus.op = 2'b00; bus.divisor_zero = 1'b0;
        idle(14);
        check("restart_first_done", int'(bus.done), 1);
        idle(7);
        bus.start = 1'b0;
        idle(40);
        check("restart_done_count", dl(DN), 2);
        check("restart_second_done", last_ev[DN] - s_cyc, 69);

        snap(); go(2'b10, 1'b0); idle(13);
        @(posedge clk); #2 reset = 1'b0; #1;
        check("midreset_outputs", int'(act), 0);
        @(negedge clk); reset = 1'b1;
        idle(45);
        check("midreset_hl_load", dl(HL), 0);
        check("midreset_done", dl(DN), 0);

`ifdef MULDIV_ABORT_EN
        snap(); go(2'b10, 1'b0); idle(6);
        check("abort_count_at", int'(bus.cycle_count), 5);
        bus.abort = 1'b1;
        @(negedge clk); bus.abort = 1'b0;
        idle(40);
        check("abort_pulses", dl(AB), 1);
        check("abort_done", dl(DN), 0);
        check("abort_hl_load", dl(HL), 0);
`endif

        repeat (600) begin
            @(negedge clk);
            bus.start = ($urandom_range(0, 3) == 0);
            bus.op = 2'($urandom);
            bus.divisor_zero = ($urandom_range(0, 3) == 0);
`ifdef MULDIV_ABORT_EN
            bus.abort = ($urandom_range(0, 29) == 0);
`endif
        end
        bus.start = 1'b0;
`ifdef MULDIV_ABORT_EN
        bus.abort = 1'b0;
`endif
        idle(40);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_c + cmp_d, err_c + err_d);
        $finish;
    end
endmodule
